// File: rtl/bsg_beat_to_word_pkg.sv
// Shared types and helpers for the beat-to-word assembler.
package bsg_beat_to_word_pkg;

    typedef enum logic {eFILL, eFULL} state_e;

    // Maps the running beat count to the lane of the word that the beat fills.
    function automatic int lane_idx(input int cnt, input int els, input bit msb_first);
        return msb_first ? (els - 1 - cnt) : cnt;
    endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear (clear wins over up) and async active-high reset.
module bsg_counter_clear_up #(
    parameter int width_p = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            count_o <= '0;
        else if (clear_i)
            count_o <= '0;
        else if (up_i)
            count_o <= count_o + 1'b1;
    end

endmodule

// File: rtl/bsg_beat_to_word.sv
// Assembles els_p narrow beats into one width_p word, presented with a v_o/yumi_i
// handshake; a new word's first beat may be taken in the same cycle the old one is consumed.
module bsg_beat_to_word
    import bsg_beat_to_word_pkg::*;
#(
    parameter int width_p     = 16,
    parameter int els_p       = 4,
    parameter int msb_first_p = 0
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [width_p/els_p-1:0] data_i,
    input  logic                     v_i,
    output logic                     ready_o,
    input  logic                     flush_i,
    output logic [width_p-1:0]       data_o,
    output logic                     v_o,
    input  logic                     yumi_i
);

    localparam int bw = width_p / els_p;
    localparam int cw = $clog2(els_p);
    localparam logic [cw-1:0] last_cnt = cw'(els_p - 1);

    if ((width_p % els_p) != 0 || els_p < 2) begin : g_bad_params
        $error("bsg_beat_to_word: width_p must be a multiple of els_p and els_p >= 2");
    end

    state_e         state_r, state_n;
    logic [cw-1:0]  cnt;
    logic [width_p-1:0] data_r;
    logic           accept, last_beat;
    int             lane;

    assign accept    = v_i & ready_o;
    assign last_beat = (cnt == last_cnt);
    assign lane      = lane_idx(int'(cnt), els_p, msb_first_p != 0);

    // Flush and word completion both return the counter to 0; in FULL cnt is already 0.
    bsg_counter_clear_up #(.width_p(cw)) beat_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (flush_i | (accept & last_beat)),
        .up_i    (accept & ~last_beat),
        .count_o (cnt)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            state_r <= eFILL;
        else
            state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        ready_o = 1'b0;
        v_o     = 1'b0;
        case (state_r)
            eFILL: begin
                ready_o = ~flush_i;
                if (accept && last_beat)
                    state_n = eFULL;
            end
            eFULL: begin
                v_o     = 1'b1;
                ready_o = yumi_i & ~flush_i;
                if (yumi_i)
                    state_n = eFILL;
            end
            default: state_n = eFILL;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            data_r <= '0;
        else
            for (int i = 0; i < els_p; i++)
                if (accept && lane == i)
                    data_r[i*bw +: bw] <= data_i;
    end

    assign data_o = data_r;

    always_ff @(posedge clk_i) begin
        if (!reset_i)
            assert (!(yumi_i && !v_o))
            else $error("bsg_beat_to_word: yumi_i asserted while v_o is low");
    end

endmodule
